// File: rtl/psum_accum.sv
// rtl/psum_accum.sv - partial-sum accumulator and row emitter after the output FIFO
module psum_accum #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int ADDR_W  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [ADDR_W-1:0]      i_cfg_rows,
  input  logic [3:0]             i_cfg_passes,
  input  logic                   i_relu_en,
  input  logic                   i_ofifo_valid,
  input  logic [COL*PSUM_BW-1:0] i_ofifo_out,
  output logic                   o_ofifo_rd,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [COL*PSUM_BW-1:0] o_out_data,
  output logic [ADDR_W-1:0]      o_out_addr,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int ROWS = 1 << ADDR_W;
  localparam int VW   = COL * PSUM_BW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_GAP,
    S_EMIT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [ADDR_W-1:0]   r_cfg_rows;
  logic [3:0]          r_cfg_passes;
  logic                r_relu;
  logic [ADDR_W-1:0]   r_row;
  logic [3:0]          r_pass;
  logic [VW-1:0]       r_acc [ROWS];
  logic [VW-1:0]       r_out_data;
  logic [ADDR_W-1:0]   r_out_addr;

  logic                w_pop;
  logic                w_final;
  logic                w_last_row;
  logic [VW-1:0]       w_acc_row;
  logic [VW-1:0]       w_sum;
  logic [VW-1:0]       w_emit;

  // Signed add clamped to the representable lane range.
  function automatic logic [PSUM_BW-1:0] sat_add(input logic [PSUM_BW-1:0] a,
                                                 input logic [PSUM_BW-1:0] b);
    logic [PSUM_BW:0] s;
    s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
    if (s[PSUM_BW] != s[PSUM_BW-1]) begin
      sat_add = s[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
    end else begin
      sat_add = s[PSUM_BW-1:0];
    end
  endfunction

  assign w_final    = (r_pass == r_cfg_passes);
  assign w_last_row = (r_row == r_cfg_rows);
  assign w_acc_row  = r_acc[r_row];
  assign w_pop      = (r_state == S_READ) && i_ofifo_valid;

  assign o_out_data = r_out_data;
  assign o_out_addr = r_out_addr;

  // Per-lane sum: first pass takes the vector as-is, later passes add saturating.
  always_comb begin
    w_sum  = '0;
    w_emit = '0;
    for (int i = 0; i < COL; i++) begin
      if (r_pass == 4'd0) begin
        w_sum[i*PSUM_BW +: PSUM_BW] = i_ofifo_out[i*PSUM_BW +: PSUM_BW];
      end else begin
        w_sum[i*PSUM_BW +: PSUM_BW] = sat_add(w_acc_row[i*PSUM_BW +: PSUM_BW],
                                              i_ofifo_out[i*PSUM_BW +: PSUM_BW]);
      end
      if (r_relu && w_sum[(i+1)*PSUM_BW-1]) begin
        w_emit[i*PSUM_BW +: PSUM_BW] = '0;
      end else begin
        w_emit[i*PSUM_BW +: PSUM_BW] = w_sum[i*PSUM_BW +: PSUM_BW];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs; a pop is only ever issued from READ, so pops never abut.
  always_comb begin
    w_next      = r_state;
    o_ofifo_rd  = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = S_READ;
        end
      end
      S_READ: begin
        o_busy     = 1'b1;
        o_ofifo_rd = i_ofifo_valid;
        if (i_ofifo_valid) begin
          w_next = w_final ? S_EMIT : S_GAP;
        end
      end
      S_GAP: begin
        o_busy = 1'b1;
        w_next = S_READ;
      end
      S_EMIT: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_next = w_last_row ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Config latch plus row/pass counters; rows advance in GAP (accumulating) or on handshake (emitting).
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cfg_rows   <= '0;
      r_cfg_passes <= '0;
      r_relu       <= 1'b0;
      r_row        <= '0;
      r_pass       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cfg_rows   <= i_cfg_rows;
            r_cfg_passes <= i_cfg_passes;
            r_relu       <= i_relu_en;
            r_row        <= '0;
            r_pass       <= '0;
          end
        end
        S_GAP: begin
          if (w_last_row) begin
            r_row  <= '0;
            r_pass <= r_pass + 4'd1;
          end else begin
            r_row <= r_row + ADDR_W'(1);
          end
        end
        S_EMIT: begin
          if (i_out_ready && !w_last_row) begin
            r_row <= r_row + ADDR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Finished-row register, loaded on the final-pass pop and held through backpressure.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_out_data <= '0;
      r_out_addr <= '0;
    end else if (w_pop && w_final) begin
      r_out_data <= w_emit;
      r_out_addr <= r_row;
    end
  end

  // Accumulator row file, written only on non-final passes.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < ROWS; i++) begin
        r_acc[i] <= '0;
      end
    end else if (w_pop && !w_final) begin
      r_acc[r_row] <= w_sum;
    end
  end

endmodule
